// File: rtl/sram_port_arbiter.sv
// Round-robin burst arbiter sharing one single-port SRAM between NREQ masters.
// Define ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module sram_port_arbiter #(
   parameter int NREQ      = 3,
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          last,
   input  logic [NREQ*ADDR_W-1:0]   addr,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*DATA_W-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [DATA_W-1:0]        rdata,
   output logic                     sram_cs,
   output logic                     sram_we,
   output logic [ADDR_W-1:0]        sram_addr,
   output logic [DATA_W-1:0]        sram_wdata,
   input  logic [DATA_W-1:0]        sram_rdata,
   output logic                     busy
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             beat;
   logic             burst_end;
   logic             dropped;
   logic             arb_en;
   logic [NREQ-1:0]  winner;

   // First set request at or above start, then wrapping around from index 0.
   function automatic logic [NREQ-1:0] pick_winner(input logic [NREQ-1:0]  r,
                                                   input logic [IDX_W-1:0] start);
      logic [NREQ-1:0] w;
      logic            found;
      w     = '0;
      found = 1'b0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && r[j] && (j >= int'(start))) begin
            w[j]  = 1'b1;
            found = 1'b1;
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!found && r[j]) begin
            w[j]  = 1'b1;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   always_comb begin
      idx = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt[j]) idx = IDX_W'(j);
      end
   end

   // gnt is one-hot, so a granted cycle without a beat means the owner dropped req.
   assign beat      = |(gnt & req);
   assign dropped   = (state == OWN) && !beat;
   assign burst_end = beat && (last[idx] || (cnt >= CNT_W'(MAX_BURST - 1)));
   assign arb_en    = (state == IDLE) || burst_end;

`ifdef ARB_FIXED_PRIO_EN
   assign winner = pick_winner(req, '0);
`else
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx_next;

   assign idx_next = (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
   assign winner   = pick_winner(req, burst_end ? idx_next : ptr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (burst_end || dropped) begin
         ptr <= idx_next;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         gnt    <= '0;
         rvalid <= '0;
         cnt    <= '0;
      end else begin
         rvalid <= (beat && !we[idx]) ? gnt : '0;
         if (arb_en && (|winner)) begin
            state <= OWN;
            gnt   <= winner;
            cnt   <= '0;
         end else if (dropped) begin
            state <= IDLE;
            gnt   <= '0;
         end else if (beat && (cnt != CNT_W'(MAX_BURST))) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      sram_addr  = '0;
      sram_wdata = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt[j]) begin
            sram_addr  = addr[j*ADDR_W +: ADDR_W];
            sram_wdata = wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   assign sram_cs = beat;
   assign sram_we = beat & we[idx];
   assign rdata   = sram_rdata;
   assign busy    = |gnt;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: grant timing, round-robin order, burst cap,
// read return, asynchronous reset and (with ARB_FIXED_PRIO_EN) fixed priority.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  last;
   logic [29:0] addr;
   logic [2:0]  we;
   logic [47:0] wdata;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [15:0] rdata;
   logic        sram_cs;
   logic        sram_we;
   logic [9:0]  sram_addr;
   logic [15:0] sram_wdata;
   logic [15:0] sram_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;

   sram_port_arbiter #(
      .NREQ(3), .ADDR_W(10), .DATA_W(16), .MAX_BURST(8)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .last(last), .addr(addr), .we(we),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: 1-cycle read latency, 0xBEEF at the top address.
   always @(posedge clk) begin
      if (sram_cs && !sram_we)
         sram_rdata <= (sram_addr == 10'h3FF) ? 16'hBEEF : {6'd0, sram_addr};
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req  = 3'b000;
      last = 3'b000;
      we   = 3'b000;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      tick;
      #2;
      checks++;
      if ({gnt, rvalid, busy, sram_cs, sram_we} !== 9'b0) begin
         errors++;
         $display("FAIL reset_state: gnt=%b rvalid=%b busy=%b cs=%b we=%b, expected all 0",
                  gnt, rvalid, busy, sram_cs, sram_we);
      end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_single_write;
      logic [9:0] exp_addr;
      req = 3'b001; we = 3'b001; last = 3'b000; addr[9:0] = 10'h010;
      #2;
      checks++;
      if ({gnt, sram_cs} !== 4'b0000) begin
         errors++;
         $display("FAIL single_no_early_gnt: gnt=%b cs=%b, expected 000/0", gnt, sram_cs);
      end
      tick;
      for (int k = 0; k < 3; k++) begin
         exp_addr    = 10'h010 + 10'(k);
         addr[9:0]   = exp_addr;
         wdata[15:0] = 16'h1000 + 16'(k);
         last        = (k == 2) ? 3'b001 : 3'b000;
         #2;
         checks++;
         if ({gnt, sram_cs, sram_we, sram_addr, sram_wdata} !==
             {3'b001, 1'b1, 1'b1, exp_addr, 16'h1000 + 16'(k)}) begin
            errors++;
            $display("FAIL single_beat%0d: gnt=%b cs=%b we=%b addr=%h wdata=%h, expected 001/1/1/%h/%h",
                     k, gnt, sram_cs, sram_we, sram_addr, sram_wdata, exp_addr, 16'h1000 + 16'(k));
         end
         tick;
      end
      idle_inputs;
      #2;
      checks++;
      if (sram_cs !== 1'b0) begin
         errors++;
         $display("FAIL single_cs_after_last: cs=%b, expected 0", sram_cs);
      end
      tick;
      #2;
      checks++;
      if ({gnt, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL single_released: gnt=%b busy=%b, expected 000/0", gnt, busy);
      end
      tick;
   endtask

   task automatic test_round_robin;
      logic [2:0] exp;
      apply_reset;
      req = 3'b111; we = 3'b111; last = 3'b000;
      for (int c = 0; c < 9; c++) begin
         last = (c > 0 && (c % 2) == 0) ? 3'b111 : 3'b000;
         exp  = (c == 0) ? 3'b000 : 3'(1 << (((c - 1) / 2) % 3));
         #2;
         checks++;
         if ({gnt, sram_cs} !== {exp, (c != 0)}) begin
            errors++;
            $display("FAIL rr_cycle%0d: gnt=%b cs=%b, expected %b/%b", c, gnt, sram_cs, exp, (c != 0));
         end
         tick;
      end
      idle_inputs;
      tick;
      tick;
      #2;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rr_idle: busy=%b, expected 0", busy);
      end
      tick;
   endtask

   task automatic test_max_burst;
      logic [2:0] exp;
      req = 3'b010; we = 3'b010; last = 3'b000;
      for (int c = 0; c < 18; c++) begin
         if (c == 12) req = 3'b110;
         exp = (c == 0) ? 3'b000 : ((c <= 16) ? 3'b010 : 3'b100);
         #2;
         checks++;
         if ({gnt, sram_cs} !== {exp, (c != 0)}) begin
            errors++;
            $display("FAIL maxburst_cycle%0d: gnt=%b cs=%b, expected %b/%b", c, gnt, sram_cs, exp, (c != 0));
         end
         tick;
      end
      idle_inputs;
      tick;
      tick;
   endtask

   task automatic test_read_return;
      req = 3'b100; we = 3'b000; last = 3'b100; addr[29:20] = 10'h3FF;
      #2;
      checks++;
      if (gnt !== 3'b000) begin
         errors++;
         $display("FAIL read_req_cycle: gnt=%b, expected 000", gnt);
      end
      tick;
      #2;
      checks++;
      if ({sram_cs, sram_we, sram_addr, rvalid} !== {1'b1, 1'b0, 10'h3FF, 3'b000}) begin
         errors++;
         $display("FAIL read_beat: cs=%b we=%b addr=%h rvalid=%b, expected 1/0/3ff/000",
                  sram_cs, sram_we, sram_addr, rvalid);
      end
      tick;
      idle_inputs;
      #2;
      checks++;
      if ({rvalid, rdata} !== {3'b100, 16'hBEEF}) begin
         errors++;
         $display("FAIL read_return: rvalid=%b rdata=%h, expected 100/beef", rvalid, rdata);
      end
      tick;
      #2;
      checks++;
      if (rvalid !== 3'b000) begin
         errors++;
         $display("FAIL read_rvalid_clear: rvalid=%b, expected 000", rvalid);
      end
      tick;
   endtask

   task automatic test_reset_mid_burst;
      // Short burst by req 1 then a drop leaves the pointer at 2.
      req = 3'b010; we = 3'b000; last = 3'b010;
      tick;
      tick;
      idle_inputs;
      tick;
      tick;
      req = 3'b010; we = 3'b000; last = 3'b000; addr[19:10] = 10'h100;
      repeat (4) tick;
      #2;
      checks++;
      if ({gnt, rvalid, sram_cs} !== {3'b010, 3'b010, 1'b1}) begin
         errors++;
         $display("FAIL rstmid_4th_beat: gnt=%b rvalid=%b cs=%b, expected 010/010/1", gnt, rvalid, sram_cs);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, rvalid, busy, sram_cs} !== 8'b0) begin
         errors++;
         $display("FAIL rstmid_async_clear: gnt=%b rvalid=%b busy=%b cs=%b, expected all 0",
                  gnt, rvalid, busy, sram_cs);
      end
      tick;
      rst = 1'b0;
      req = 3'b111; we = 3'b000; last = 3'b111;
      #2;
      checks++;
      if (gnt !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_no_early_gnt: gnt=%b, expected 000", gnt);
      end
      tick;
      #2;
      checks++;
      if (gnt !== 3'b001) begin
         errors++;
         $display("FAIL rstmid_first_grant: gnt=%b, expected 001", gnt);
      end
      idle_inputs;
      tick;
      tick;
      tick;
   endtask

   task automatic test_priority;
      logic [2:0] exp_after;
`ifdef ARB_FIXED_PRIO_EN
      exp_after = 3'b001;
`else
      exp_after = 3'b100;
`endif
      apply_reset;
      req = 3'b110; we = 3'b000; last = 3'b000;
      #2;
      checks++;
      if (gnt !== 3'b000) begin
         errors++;
         $display("FAIL prio_req_cycle: gnt=%b, expected 000", gnt);
      end
      tick;
      for (int c = 1; c < 4; c++) begin
         if (c == 2) req = 3'b111;
         if (c == 3) last = 3'b010;
         #2;
         checks++;
         if (gnt !== 3'b010) begin
            errors++;
            $display("FAIL prio_hold_cycle%0d: gnt=%b, expected 010", c, gnt);
         end
         tick;
      end
      last = 3'b000;
      #2;
      checks++;
      if ({gnt, sram_cs} !== {exp_after, 1'b1}) begin
         errors++;
         $display("FAIL prio_next_owner: gnt=%b cs=%b, expected %b/1", gnt, sram_cs, exp_after);
      end
      idle_inputs;
      tick;
      tick;
   endtask

   initial begin
      rst   = 1'b1;
      addr  = '0;
      wdata = '0;
      idle_inputs;
      test_reset;
      test_single_write;
      test_round_robin;
      test_max_burst;
      test_read_return;
      test_reset_mid_burst;
      test_priority;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single-port activation/weight SRAM between the accelerator's three masters: weight loader (req 0), input loader (req 1) and compute/writeback engine (req 2).
- Sits between those masters and the SRAM macro, beside the top-level ctrl FSM.
- Grants bursts round-robin, caps burst length, muxes address/data onto the SRAM port and routes 1-cycle-latency read data back to the owner.

Parameters:
NREQ, 3, number of requesters
ADDR_W, 10, SRAM address width
DATA_W, 16, SRAM data width
MAX_BURST, 8, max beats per grant (>=1); counter width is $clog2(MAX_BURST+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  NREQ  per-requester access request, held high for the whole burst
last  input  NREQ  marks the final beat of requester i's burst
addr  input  NREQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W]
we  input  NREQ  per-requester write enable (1 = write, 0 = read)
wdata  input  NREQ*DATA_W  per-requester write data
gnt  output  NREQ  registered one-hot grant
rvalid  output  NREQ  read data valid, one-hot, for the requester that issued the read
rdata  output  DATA_W  read data, broadcast to all requesters
sram_cs  output  1  SRAM chip select
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data, valid 1 cycle after a read beat
busy  output  1  high while any grant is held

Behaviour:
- Reset values: gnt=0, rvalid=0, busy=0, rr pointer=0, beat count=0, state=IDLE. sram_cs/sram_we are 0 while gnt=0.
- States:
  - IDLE: no grant.
  - OWN: exactly one gnt bit is set.
- Arbitration happens in IDLE, and in OWN on the burst-end cycle.
  - Winner = first set req bit scanning from ptr upward, with wrap-around.
  - Winner's gnt is registered and visible the next cycle. No grant is given in the request cycle itself.
- Beat = any cycle where gnt[i] & req[i]. On a beat, combinationally from slice i:
  - sram_cs=1
  - sram_we=we[i]
  - sram_addr=addr slice i
  - sram_wdata=wdata slice i
- Outside a beat, sram_cs=0 and sram_we=0. addr/wdata outputs are don't-care.
- Read return: a read beat by i produces rvalid[i]=1 the next cycle, with rdata=sram_rdata passed through unregistered.
- Burst end, evaluated in the beat cycle: last[i]=1, or beat count reaches MAX_BURST.
  - ptr <= i+1, mod NREQ.
  - Re-arbitration happens in the same cycle with the updated ptr; gnt switches next cycle with no idle bubble.
  - If no other req is pending, the same requester may win again.
- Requester drops req while granted: the grant is revoked next cycle (gnt=0, state IDLE), ptr advances past i, no beat is issued.
- Beat counter: cleared on every new grant, increments per beat, saturates at MAX_BURST.
- Requests arriving during OWN wait. No preemption.
- busy = |gnt.
- Reset asserted mid-burst: all state clears immediately and asynchronously, and any pending rvalid is dropped.
  - After deassertion, arbitration restarts at ptr=0.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, index 0 highest. The ptr register is not implemented; winner = lowest set req bit. All burst-end rules and MAX_BURST limits are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then req=3'b001 with we=1, 3 beats at addr 0x010..0x012, last on beat 3:
  - gnt=001 one cycle after req.
  - sram_cs high for 3 cycles; sram_addr 0x010,0x011,0x012; sram_we=1.
  - gnt=000 after the last beat.
- req=3'b111 held, every requester asserts last on its 2nd beat:
  - Grant order 001,010,100,001 with no idle cycles between bursts.
  - Each burst is exactly 2 sram_cs cycles.
- req[1] held with no last, MAX_BURST=8:
  - Burst cut after exactly 8 beats.
  - With req[2] pending, gnt moves to 100; with nothing pending, req 1 regains the grant next cycle.
- Read beat by req 2 at addr 0x3FF with sram_rdata model 0xBEEF:
  - rvalid=100 and rdata=0xBEEF exactly one cycle after the beat; rvalid[0] and rvalid[1] stay 0.
- rst pulsed during the 4th beat of a burst:
  - gnt, rvalid, busy and sram_cs drop to 0 without waiting for a clock edge.
  - First grant after reset starts from index 0.
- With ARB_FIXED_PRIO_EN defined, req=3'b110 then req[0] rising mid-burst:
  - req 0 waits for the current burst to end, then wins ahead of req 2.
